// File: rtl/weight_stream_loader_pkg.sv
// Shared definitions for weight_stream_loader: layer codes, FSM states and layer geometry helpers.
package weight_stream_loader_pkg;

    localparam int unsigned LAYER_H1  = 1;
    localparam int unsigned LAYER_H2  = 2;
    localparam int unsigned LAYER_OUT = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Weight count of a layer: nodes * (fan_in + bias)
    function automatic int unsigned layer_words(input int unsigned layer, input int unsigned n_in,
                                                input int unsigned n_h1, input int unsigned n_h2,
                                                input int unsigned n_out);
        case (layer)
            LAYER_H1:  return n_h1 * (n_in + 1);
            LAYER_H2:  return n_h2 * (n_h1 + 1);
            LAYER_OUT: return n_out * (n_h2 + 1);
            default:   return 0;
        endcase
    endfunction

    function automatic int unsigned layer_base(input int unsigned layer, input int unsigned n_in,
                                               input int unsigned n_h1, input int unsigned n_h2,
                                               input int unsigned n_out);
        case (layer)
            LAYER_H2:  return layer_words(LAYER_H1, n_in, n_h1, n_h2, n_out);
            LAYER_OUT: return layer_words(LAYER_H1, n_in, n_h1, n_h2, n_out)
                            + layer_words(LAYER_H2, n_in, n_h1, n_h2, n_out);
            default:   return 0;
        endcase
    endfunction

endpackage

// File: rtl/weight_stream_loader_if.sv
// Memory read port and weight beat stream between the loader, the weight RAM and main_net.
interface weight_stream_loader_if #(
    parameter int unsigned DATA_WIDTH           = 32,
    parameter int unsigned LAYER_WIDTH          = 2,
    parameter int unsigned WEIGHT_COUNTER_WIDTH = 11,
    parameter int unsigned MEM_ADDR_WIDTH       = 12
);
    logic                            mem_rd_en;
    logic [MEM_ADDR_WIDTH-1:0]       mem_rd_addr;
    logic [DATA_WIDTH-1:0]           mem_rd_data;
    logic                            weight_valid;
    logic                            weight_ready;
    logic [LAYER_WIDTH-1:0]          weight_layer;
    logic [WEIGHT_COUNTER_WIDTH-1:0] weight_addr;
    logic [DATA_WIDTH-1:0]           weight;

    modport master (
        output mem_rd_en, mem_rd_addr, weight_valid, weight_layer, weight_addr, weight,
        input  mem_rd_data, weight_ready
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr, weight_valid, weight_layer, weight_addr, weight,
        output mem_rd_data, weight_ready
    );
endinterface

// File: rtl/weight_skid_fifo.sv
// Two-entry FIFO with a dedicated head register so the beat outputs come straight from flops.
module weight_skid_fifo #(
    parameter int unsigned WIDTH = 45
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] tail_q;

    // Callers never push when full nor pop when empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head   <= '0;
            tail_q <= '0;
            count  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= push_data;
                    else               tail_q <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail_q;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= push_data;
                    end else begin
                        head   <= tail_q;
                        tail_q <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/weight_stream_loader.sv
// Streams network weights from flat memory to main_net with backpressure and single-layer reload.
// Optional running checksum of accepted weights when LOADER_CHECKSUM_EN is defined.
module weight_stream_loader
    import weight_stream_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH                    = 32,
    parameter int unsigned LAYER_WIDTH                   = 2,
    parameter int unsigned NUMBER_OF_INPUT_NODE          = 2,
    parameter int unsigned NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
    parameter int unsigned NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
    parameter int unsigned NUMBER_OF_OUTPUT_NODE         = 3,
    parameter int unsigned WEIGHT_COUNTER_WIDTH          = 11,
    parameter int unsigned MEM_ADDR_WIDTH                = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic                   i_mode,
    input  logic [LAYER_WIDTH-1:0] i_layer_sel,
    output logic                   o_busy,
    output logic                   o_done,
    weight_stream_loader_if.master bus
`ifdef LOADER_CHECKSUM_EN
   ,output logic [DATA_WIDTH-1:0]  o_checksum
`endif
);
    localparam int unsigned NI = NUMBER_OF_INPUT_NODE;
    localparam int unsigned N1 = NUMBER_OF_HIDDEN_NODE_LAYER_1;
    localparam int unsigned N2 = NUMBER_OF_HIDDEN_NODE_LAYER_2;
    localparam int unsigned NO = NUMBER_OF_OUTPUT_NODE;
    localparam int unsigned W1 = layer_words(LAYER_H1, NI, N1, N2, NO);
    localparam int unsigned W2 = layer_words(LAYER_H2, NI, N1, N2, NO);
    localparam int unsigned W3 = layer_words(LAYER_OUT, NI, N1, N2, NO);
    localparam int unsigned B2 = layer_base(LAYER_H2, NI, N1, N2, NO);
    localparam int unsigned B3 = layer_base(LAYER_OUT, NI, N1, N2, NO);
    localparam int unsigned BEAT_WIDTH = LAYER_WIDTH + WEIGHT_COUNTER_WIDTH + DATA_WIDTH;

    state_t                          state_q, state_d;
    logic [LAYER_WIDTH-1:0]          layer_q, last_q, pend_layer_q;
    logic [WEIGHT_COUNTER_WIDTH-1:0] local_q, pend_addr_q;
    logic                            rd_pending_q;
    logic                            start_ok, rd_en, pop, final_word;
    logic [1:0]                      fifo_count;
    logic [BEAT_WIDTH-1:0]           fifo_head;
    int unsigned                     words_cur, base_cur;

    // Geometry of the layer currently being read
    always_comb begin
        words_cur = 0;
        base_cur  = 0;
        case (layer_q)
            LAYER_WIDTH'(LAYER_H1):  begin words_cur = W1; base_cur = 0;  end
            LAYER_WIDTH'(LAYER_H2):  begin words_cur = W2; base_cur = B2; end
            LAYER_WIDTH'(LAYER_OUT): begin words_cur = W3; base_cur = B3; end
            default: ;
        endcase
    end

    assign start_ok   = i_start && !(i_mode && (i_layer_sel == '0));
    assign pop        = (fifo_count != 2'd0) && bus.weight_ready;
    assign final_word = (local_q == WEIGHT_COUNTER_WIDTH'(words_cur - 32'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Reads are credited against FIFO space so a returning word always has a slot
    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        case (state_q)
            IDLE: if (start_ok) state_d = RUN;
            RUN: begin
                rd_en = (3'(fifo_count) + 3'(rd_pending_q) - 3'(pop)) < 3'd2;
                if (rd_en && final_word && (layer_q == last_q)) state_d = DRAIN;
            end
            DRAIN: begin
                if (!rd_pending_q && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop)))
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer_q      <= '0;
            last_q       <= '0;
            local_q      <= '0;
            pend_layer_q <= '0;
            pend_addr_q  <= '0;
            rd_pending_q <= 1'b0;
        end else begin
            rd_pending_q <= rd_en;
            if (rd_en) begin
                pend_layer_q <= layer_q;
                pend_addr_q  <= local_q;
            end
            if ((state_q == IDLE) && start_ok) begin
                layer_q <= i_mode ? i_layer_sel : LAYER_WIDTH'(LAYER_H1);
                last_q  <= i_mode ? i_layer_sel : LAYER_WIDTH'(LAYER_OUT);
                local_q <= '0;
            end else if (rd_en) begin
                if (final_word) begin
                    local_q <= '0;
                    if (layer_q != last_q) layer_q <= layer_q + LAYER_WIDTH'(1);
                end else begin
                    local_q <= local_q + WEIGHT_COUNTER_WIDTH'(1);
                end
            end
        end
    end

    weight_skid_fifo #(.WIDTH(BEAT_WIDTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_pending_q),
        .push_data ({pend_layer_q, pend_addr_q, bus.mem_rd_data}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign bus.mem_rd_en    = rd_en;
    assign bus.mem_rd_addr  = rd_en ? (MEM_ADDR_WIDTH'(base_cur) + MEM_ADDR_WIDTH'(local_q)) : '0;
    assign bus.weight_valid = (fifo_count != 2'd0);
    assign {bus.weight_layer, bus.weight_addr, bus.weight} = fifo_head;
    assign o_busy = (state_q == RUN) || (state_q == DRAIN);
    assign o_done = (state_q == DONE);

`ifdef LOADER_CHECKSUM_EN
    // Rotate-left-by-one then fold in each accepted weight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_checksum <= '0;
        end else if ((state_q == IDLE) && start_ok) begin
            o_checksum <= '0;
        end else if (pop) begin
            o_checksum <= {o_checksum[DATA_WIDTH-2:0], o_checksum[DATA_WIDTH-1]} ^ bus.weight;
        end
    end
`endif
endmodule
